vector_fu: RTL and testbench
============================

Name: vector_fu

Overview:
- Downstream consumer of the tile memory stage.
- Drives `on_off` to request an operand read, then captures `config_in` plus 2*num_inputs operands when `r_data_vld` is asserted.
- Executes one lane-wise vector op and sends the num_inputs-wide result to up to two neighbour tiles.
- The send uses the network write handshake: `write_en` is held until `write_ack`.

Parameters:
- width, 16, data/config word width (>= 8).
- num_inputs, 4, result lanes; operand count = 2*num_inputs.
- total_inputs, num_inputs+num_inputs, operand vector length.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  tile run enable; sampled in IDLE.
- on_off  out  1  read request to memory stage.
- on_off_vector_fu  in  1  memory grant (request and no write in progress).
- r_data_vld  in  1  operands/config valid this cycle.
- config_in  in  width  op config word.
- adder_inputs  in  width x total_inputs  operands; A = [0..num_inputs-1], B = [num_inputs..total_inputs-1].
- write_en1  out  1  send request to neighbour 1.
- write_ack1  in  1  neighbour 1 accepted.
- w_data_out1  out  width x num_inputs  result to neighbour 1.
- write_en2  out  1  send request to neighbour 2.
- write_ack2  in  1  neighbour 2 accepted.
- w_data_out2  out  width x num_inputs  result to neighbour 2 (same value as w_data_out1).
- busy  out  1  state != IDLE.
- op_count  out  16  completed ops, wraps at 0xFFFF -> 0.

Behaviour:
- Reset: all outputs 0; state = IDLE; result register 0; per-port done flags 0. Reset mid-operation aborts; `write_en*` drops at that edge.
- Config decode:
  - [2:0] opcode: 0 ADD, 1 SUB (A-B), 2 MUL (low width bits), 3 AND, 4 OR, 5 XOR, 6 PASS_A, 7 NOP.
  - [4] send to port 1; [5] send to port 2. Other bits are ignored.
- Arithmetic: modulo 2^width. No saturation, no flags.
- IDLE: `on_off` = 0. If `enable` = 1, go to REQ and assert `on_off` on the next cycle.
- REQ:
  - `on_off` = 1.
  - On a cycle with `r_data_vld` = 1: capture config and all operands, deassert `on_off` at that edge, go to EXEC.
  - If `enable` falls before `r_data_vld`: go to IDLE, `on_off` -> 0, nothing captured.
- EXEC (1 cycle): register res[i] = op(A[i], B[i]).
  - If opcode = NOP or config[5:4] = 0: increment `op_count`, go to IDLE, no send.
  - Otherwise go to SEND.
- SEND:
  - `write_enN` = 1 for each selected port whose done flag is clear.
  - `w_data_out*` stays stable for the whole of SEND.
  - When `write_ackN` = 1 while `write_enN` = 1: set doneN, drop `write_enN` at the next edge.
  - Both acks in the same cycle are legal.
  - When all selected ports are done: increment `op_count`, clear flags, go to IDLE.
  - Acks on unselected ports, or outside SEND, are ignored.
  - No timeout.
- Latency, `enable` to first `write_en`: IDLE 1 cycle + REQ until valid + EXEC 1 cycle. With valid on the first REQ cycle, `write_en` rises 3 cycles after `enable` is sampled.
- `on_off` is never asserted while `write_en1` or `write_en2` is high.
- Back-to-back ops: return to IDLE takes one cycle before the next REQ (no overlap).

Decomposition:
- Package vfu_pkg:
  - opcode enum (ADD..NOP), `vfu_state_t` {IDLE, REQ, EXEC, SEND};
  - constants OPC_LSB = 0, OPC_W = 3, SEND1_BIT = 4, SEND2_BIT = 5.
- Sub-module vfu_alu: combinational, num_inputs lanes, width-parameterised; opcode + A/B vectors -> result vector.

Test Plan:
- ADD, both ports:
  - Stimulus: config = 0x0030, A = {1,2,3,4}, B = {10,20,30,40}, valid on first REQ cycle, acks 2 cycles after `write_en`.
  - Required: out = {11,22,33,44} on both ports; `write_en` rises 3 cycles after `enable`; `op_count` = 1.
- SUB wrap:
  - Stimulus: config = 0x0011, A = {0,...}, B = {1,...}.
  - Required: out lane0 = 0xFFFF on port 1 only; `write_en2` never asserted.
- Staggered acks:
  - Stimulus: `write_ack1` at SEND cycle 1, `write_ack2` at cycle 5.
  - Required: `write_en1` drops after cycle 1; `write_en2` is held through cycle 5; data stable throughout; single `op_count` increment.
- NOP / no-port:
  - Stimulus: config = 0x0037, then 0x0000 with ADD.
  - Required: no `write_en`; `op_count` +1 each; `busy` returns low 2 cycles after capture.
- Stall and abort:
  - Stimulus: hold `r_data_vld` = 0 for 10 cycles with `on_off` = 1, drop `enable`.
  - Required: IDLE next cycle, `on_off` = 0, `op_count` unchanged.
- Reset mid-SEND:
  - Stimulus: assert `reset` while `write_en1` = 1.
  - Required: next edge has all outputs 0, `op_count` = 0, state IDLE.

Source files
------------

// File: rtl/vfu_pkg.sv
// Shared types and constants for the vector functional unit.
//   vfu_op_t    : lane-wise opcode carried in config[2:0]
//   vfu_state_t : control FSM states
//   vfu_cfg_t   : decoded config word held for the whole operation
package vfu_pkg;

    localparam int OPC_LSB   = 0;
    localparam int OPC_W     = 3;
    localparam int SEND1_BIT = 4;
    localparam int SEND2_BIT = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_MUL    = 3'd2,
        OP_AND    = 3'd3,
        OP_OR     = 3'd4,
        OP_XOR    = 3'd5,
        OP_PASS_A = 3'd6,
        OP_NOP    = 3'd7
    } vfu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        SEND = 2'd3
    } vfu_state_t;

    typedef struct packed {
        vfu_op_t op;
        logic    send1;
        logic    send2;
    } vfu_cfg_t;

endpackage

// File: rtl/vfu_alu.sv
// Combinational lane-wise ALU: res[i] = op(a[i], b[i]), modulo 2^width.
//   op  : opcode
//   a,b : operand vectors, num_inputs lanes of width bits
//   res : result vector (NOP yields zero; the caller does not register it)
module vfu_alu
    import vfu_pkg::*;
#(
    parameter int width      = 16,
    parameter int num_inputs = 4
) (
    input  vfu_op_t                              op,
    input  logic [num_inputs-1:0][width-1:0]     a,
    input  logic [num_inputs-1:0][width-1:0]     b,
    output logic [num_inputs-1:0][width-1:0]     res
);

    for (genvar i = 0; i < num_inputs; i++) begin : g_lane
        logic [width-1:0] lane_res;

        always_comb begin
            lane_res = '0;
            case (op)
                OP_ADD:    lane_res = a[i] + b[i];
                OP_SUB:    lane_res = a[i] - b[i];
                OP_MUL:    lane_res = a[i] * b[i];  // keeps low width bits
                OP_AND:    lane_res = a[i] & b[i];
                OP_OR:     lane_res = a[i] | b[i];
                OP_XOR:    lane_res = a[i] ^ b[i];
                OP_PASS_A: lane_res = a[i];
                default:   lane_res = '0;
            endcase
        end

        assign res[i] = lane_res;
    end

endmodule

// File: rtl/vector_fu.sv
// Vector functional unit fed by the tile memory stage.
// Requests operands (on_off), captures config + 2*num_inputs operands on
// r_data_vld, runs one lane-wise op and sends the result to up to two
// neighbours with a hold-until-ack write handshake.
//   clk, reset           : clock, synchronous active-high reset
//   enable               : run enable (sampled in IDLE, abort in REQ)
//   on_off               : operand read request
//   on_off_vector_fu     : memory grant (informational only)
//   r_data_vld           : config_in / adder_inputs valid
//   adder_inputs         : A = lanes [0..num_inputs-1], B = the rest
//   write_enN/write_ackN : neighbour N send handshake
//   w_data_outN          : result vector (same on both ports)
//   busy                 : not IDLE
//   op_count             : completed operations, wraps
module vector_fu
    import vfu_pkg::*;
#(
    parameter int width        = 16,
    parameter int num_inputs   = 4,
    parameter int total_inputs = num_inputs + num_inputs
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    output logic                                   on_off,
    input  logic                                   on_off_vector_fu,
    input  logic                                   r_data_vld,
    input  logic [width-1:0]                       config_in,
    input  logic [total_inputs-1:0][width-1:0]     adder_inputs,
    output logic                                   write_en1,
    input  logic                                   write_ack1,
    output logic [num_inputs-1:0][width-1:0]       w_data_out1,
    output logic                                   write_en2,
    input  logic                                   write_ack2,
    output logic [num_inputs-1:0][width-1:0]       w_data_out2,
    output logic                                   busy,
    output logic [15:0]                            op_count
);

    vfu_state_t                       state_q, state_d;
    vfu_cfg_t                         cfg_q, cfg_d;
    logic [num_inputs-1:0][width-1:0] a_q, a_d, b_q, b_d;
    logic [num_inputs-1:0][width-1:0] res_q, res_d, alu_res;
    logic                             done1_q, done1_d, done2_q, done2_d;
    logic [15:0]                      cnt_q, cnt_d;

    // The grant is implied by the memory stage only answering while we
    // request; unused config bits are ignored by design.
    logic in_unused;
    assign in_unused = on_off_vector_fu ^ (^config_in);

    vfu_alu #(.width(width), .num_inputs(num_inputs)) u_alu (
        .op  (cfg_q.op),
        .a   (a_q),
        .b   (b_q),
        .res (alu_res)
    );

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        done1_d = done1_q;
        done2_d = done2_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (enable) state_d = REQ;
            REQ: begin
                // Valid data wins over a simultaneous enable drop.
                if (r_data_vld) begin
                    cfg_d.op    = vfu_op_t'(config_in[OPC_LSB +: OPC_W]);
                    cfg_d.send1 = config_in[SEND1_BIT];
                    cfg_d.send2 = config_in[SEND2_BIT];
                    for (int i = 0; i < num_inputs; i++) begin
                        a_d[i] = adder_inputs[i];
                        b_d[i] = adder_inputs[num_inputs + i];
                    end
                    state_d = EXEC;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cfg_q.op != OP_NOP) res_d = alu_res;
                if (cfg_q.op == OP_NOP || !(cfg_q.send1 || cfg_q.send2)) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (write_en1 && write_ack1) done1_d = 1'b1;
                if (write_en2 && write_ack2) done2_d = 1'b1;
                if ((!cfg_q.send1 || done1_d) && (!cfg_q.send2 || done2_d)) begin
                    done1_d = 1'b0;
                    done2_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cfg_q   <= '{op: OP_ADD, send1: 1'b0, send2: 1'b0};
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode from registered state, so on_off and write_en*
    // are mutually exclusive by construction.
    assign on_off      = (state_q == REQ);
    assign write_en1   = (state_q == SEND) && cfg_q.send1 && !done1_q;
    assign write_en2   = (state_q == SEND) && cfg_q.send2 && !done2_q;
    assign w_data_out1 = res_q;
    assign w_data_out2 = res_q;
    assign busy        = (state_q != IDLE);
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_vector_fu.sv
module tb_vector_fu;

    logic                clk = 1'b0;
    logic                reset, enable, on_off, on_off_vector_fu, r_data_vld;
    logic [15:0]         config_in;
    logic [7:0][15:0]    adder_inputs;
    logic                write_en1, write_ack1, write_en2, write_ack2, busy;
    logic [3:0][15:0]    w_data_out1, w_data_out2;
    logic [15:0]         op_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vector_fu dut (
        .clk(clk), .reset(reset), .enable(enable), .on_off(on_off),
        .on_off_vector_fu(on_off_vector_fu), .r_data_vld(r_data_vld),
        .config_in(config_in), .adder_inputs(adder_inputs),
        .write_en1(write_en1), .write_ack1(write_ack1), .w_data_out1(w_data_out1),
        .write_en2(write_en2), .write_ack2(write_ack2), .w_data_out2(w_data_out2),
        .busy(busy), .op_count(op_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive after the edge settles; checks happen here too, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // IDLE -> REQ -> EXEC -> (SEND | IDLE); returns just after the third edge.
    task automatic start_op(input logic [15:0] cfg, input logic [3:0][15:0] a,
                            input logic [3:0][15:0] b);
        config_in = cfg;
        for (int i = 0; i < 4; i++) begin
            adder_inputs[i]     = a[i];
            adder_inputs[4 + i] = b[i];
        end
        enable = 1'b1;
        r_data_vld = 1'b1;
        step();
        step();
        enable = 1'b0;
        r_data_vld = 1'b0;
        step();
    endtask

    logic [63:0] exp_v;

    initial begin
        reset = 1'b1; enable = 1'b0; r_data_vld = 1'b0; on_off_vector_fu = 1'b1;
        config_in = '0; adder_inputs = '0; write_ack1 = 1'b0; write_ack2 = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_on_off", 64'(on_off), 64'd0);
        chk("rst_wen", 64'({write_en1, write_en2}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(op_count), 64'd0);
        chk("rst_data", w_data_out1, 64'd0);

        // ADD to both ports, latency check edge by edge
        config_in = 16'h0030;
        adder_inputs = {16'd40, 16'd30, 16'd20, 16'd10, 16'd4, 16'd3, 16'd2, 16'd1};
        enable = 1'b1; r_data_vld = 1'b1;
        step();
        chk("add_req_on_off", 64'(on_off), 64'd1);
        chk("add_req_wen", 64'({write_en1, write_en2}), 64'd0);
        step();
        enable = 1'b0; r_data_vld = 1'b0;
        chk("add_exec_on_off", 64'(on_off), 64'd0);
        chk("add_exec_wen", 64'({write_en1, write_en2}), 64'd0);
        step();
        chk("add_lat_wen", 64'({write_en1, write_en2}), 64'b11);
        chk("add_send_on_off", 64'(on_off), 64'd0);
        exp_v = {16'd44, 16'd33, 16'd22, 16'd11};
        chk("add_out1", w_data_out1, exp_v);
        chk("add_out2", w_data_out2, exp_v);
        step();
        step();
        chk("add_hold_wen", 64'({write_en1, write_en2}), 64'b11);
        write_ack1 = 1'b1; write_ack2 = 1'b1;
        step();
        write_ack1 = 1'b0; write_ack2 = 1'b0;
        chk("add_done_wen", 64'({write_en1, write_en2}), 64'd0);
        chk("add_done_busy", 64'(busy), 64'd0);
        chk("add_cnt", 64'(op_count), 64'd1);

        // SUB wrap, port 1 only
        start_op(16'h0011, {16'd0, 16'd0, 16'd0, 16'd0}, {16'd1, 16'd1, 16'd1, 16'd1});
        chk("sub_wen", 64'({write_en1, write_en2}), 64'b10);
        chk("sub_out1", w_data_out1, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("sub_wen2_low", 64'(write_en2), 64'd0);
        write_ack1 = 1'b1; write_ack2 = 1'b1;  // ack2 on unselected port is ignored
        step();
        write_ack1 = 1'b0; write_ack2 = 1'b0;
        chk("sub_done_wen", 64'({write_en1, write_en2}), 64'd0);
        chk("sub_cnt", 64'(op_count), 64'd2);

        // MUL keeps low bits, port 1
        start_op(16'h0012, {16'd7, 16'hFFFF, 16'd3, 16'h0100},
                           {16'd0, 16'd2, 16'd5, 16'h0100});
        chk("mul_out1", w_data_out1, {16'd0, 16'hFFFE, 16'd15, 16'd0});
        write_ack1 = 1'b1;
        step();
        write_ack1 = 1'b0;
        chk("mul_cnt", 64'(op_count), 64'd3);

        // XOR, port 2 only
        start_op(16'h0025, {16'h0000, 16'hFFFF, 16'h1234, 16'hF0F0},
                           {16'h0000, 16'h0001, 16'h1234, 16'h0FF0});
        chk("xor_wen", 64'({write_en1, write_en2}), 64'b01);
        chk("xor_out2", w_data_out2, {16'h0000, 16'hFFFE, 16'h0000, 16'hFF00});
        write_ack2 = 1'b1;
        step();
        write_ack2 = 1'b0;
        chk("xor_cnt", 64'(op_count), 64'd4);

        // AND with staggered acks: ack1 in SEND cycle 1, ack2 in cycle 5
        start_op(16'h0033, {16'h1234, 16'h0F0F, 16'h00FF, 16'hFFFF},
                           {16'h00FF, 16'hFF00, 16'hFFFF, 16'h0F0F});
        exp_v = {16'h0034, 16'h0F00, 16'h00FF, 16'h0F0F};
        chk("stg_c1_wen", 64'({write_en1, write_en2}), 64'b11);
        write_ack1 = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            write_ack1 = 1'b0;
            chk($sformatf("stg_c%0d_wen", k), 64'({write_en1, write_en2}), 64'b01);
            chk($sformatf("stg_c%0d_data", k), w_data_out1, exp_v);
            chk($sformatf("stg_c%0d_cnt", k), 64'(op_count), 64'd4);
        end
        write_ack2 = 1'b1;
        step();
        write_ack2 = 1'b0;
        chk("stg_done_wen", 64'({write_en1, write_en2}), 64'd0);
        chk("stg_cnt", 64'(op_count), 64'd5);

        // NOP with both ports selected, then ADD with no port
        start_op(16'h0037, {16'd1, 16'd1, 16'd1, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1});
        chk("nop_wen", 64'({write_en1, write_en2}), 64'd0);
        chk("nop_busy", 64'(busy), 64'd0);
        chk("nop_cnt", 64'(op_count), 64'd6);
        start_op(16'h0000, {16'd1, 16'd1, 16'd1, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1});
        chk("noport_wen", 64'({write_en1, write_en2}), 64'd0);
        chk("noport_busy", 64'(busy), 64'd0);
        chk("noport_cnt", 64'(op_count), 64'd7);

        // Stall in REQ for 10 cycles, then abort
        config_in = 16'h0030;
        enable = 1'b1; r_data_vld = 1'b0;
        step();
        for (int k = 0; k < 10; k++) step();
        chk("stall_on_off", 64'(on_off), 64'd1);
        chk("stall_busy", 64'(busy), 64'd1);
        enable = 1'b0;
        step();
        chk("abort_on_off", 64'(on_off), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cnt", 64'(op_count), 64'd7);

        // Reset while write_en1 is high
        start_op(16'h0010, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1});
        chk("rsend_wen1", 64'(write_en1), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rsend_wen", 64'({write_en1, write_en2}), 64'd0);
        chk("rsend_on_off", 64'(on_off), 64'd0);
        chk("rsend_busy", 64'(busy), 64'd0);
        chk("rsend_cnt", 64'(op_count), 64'd0);
        chk("rsend_data", w_data_out1, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
